piso_bit_serializer: RTL

- Parallel-in, serial-out stage directly upstream of the Mealy 1101 sequence detector; its dout drives the detector's din.
- Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clock.
- Double-buffered (shift register plus one holding register), so back-to-back words stream with no idle bit between frames.

---
 rtl/piso_pkg.sv | 15 +
 rtl/piso_hold_buf.sv | 22 ++
 rtl/piso_bit_serializer.sv | 79 +++++++
 3 files changed

// File: rtl/piso_pkg.sv
// piso_pkg: state type and frame sizing shared by piso_bit_serializer.
// Defining PISO_BIT_SERIALIZER_PARITY_EN adds an even-parity bit to every frame.
package piso_pkg;
    typedef enum logic {IDLE, SHIFT} state_t;
    function automatic int frame_len(input int width);
`ifdef PISO_BIT_SERIALIZER_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction
endpackage

// File: rtl/piso_hold_buf.sv
// piso_hold_buf: single-entry holding register that lets a word wait behind the shifting one.
module piso_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q,
    output logic             hold_full
);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q         <= '0;
            hold_full <= 1'b0;
        end else begin
            if (wr) q <= data;
            hold_full <= wr ? 1'b1 : rd ? 1'b0 : hold_full;
        end
    end
endmodule

// File: rtl/piso_bit_serializer.sv
// piso_bit_serializer: double-buffered parallel-in serial-out stage feeding the 1101 detector.
// Defining PISO_BIT_SERIALIZER_PARITY_EN appends an even-parity bit to each frame.
module piso_bit_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_last,
    output logic             busy
);
    localparam int FRAME_LEN = frame_len(WIDTH);
    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shift, hold_q, new_word;
    logic             hold_full, accept, last, hold_wr, hold_rd, reload, data_bit, out_bit;

    assign load_ready = !hold_full;
    assign accept     = load_valid && load_ready;
    assign last       = state == SHIFT && bit_cnt == LAST;
    assign hold_wr    = accept && state == SHIFT && !last;
    assign hold_rd    = last && hold_full;
    // A waiting word always wins at the frame boundary; otherwise a same-cycle accept bypasses hold.
    assign reload     = (state == IDLE && accept) || (last && (hold_full || accept));
    assign new_word   = hold_full ? hold_q : load_data;
    assign data_bit   = MSB_FIRST ? shift[WIDTH-1] : shift[0];

    piso_hold_buf #(.WIDTH(WIDTH)) u_hold (
        .clock     (clock),
        .reset     (reset),
        .wr        (hold_wr),
        .rd        (hold_rd),
        .data      (load_data),
        .q         (hold_q),
        .hold_full (hold_full)
    );

`ifdef PISO_BIT_SERIALIZER_PARITY_EN
    logic parity;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) parity <= 1'b0;
        else if (reload) parity <= ^new_word;
    end
    assign out_bit = bit_cnt == LAST ? parity : data_bit;
`else
    assign out_bit = data_bit;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
        end else if (reload) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            shift   <= new_word;
        end else if (state == SHIFT) begin
            state   <= last ? IDLE : SHIFT;
            bit_cnt <= last ? '0 : bit_cnt + 1'b1;
            shift   <= MSB_FIRST ? shift << 1 : shift >> 1;
        end
    end

    assign dout_valid = state == SHIFT;
    assign dout       = dout_valid && out_bit;
    assign frame_last = last;
    assign busy       = state == SHIFT || hold_full;
endmodule
